// File: rtl/shift_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_bank
//  Description : Bank of NUM_REGS shift registers, WIDTH bits each, with a
//                shared parallel load bus and a burst shifter. A single
//                Start runs a programmed number of left or right shifts.
//                Each register can shift on its own, or all of them can be
//                joined into one long register (chain mode).
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk      in   1                rising-edge clock
//    i_rst_n    in   1                asynchronous active-low reset
//    i_d        in   WIDTH            parallel load data
//    i_ld       in   NUM_REGS         per-register load enable (IDLE/DONE only)
//    i_start    in   1                start a burst (sampled in IDLE only)
//    i_count    in   CNT_W            shifts in the burst, sampled with start
//    i_sel      in   NUM_REGS         registers in the burst, sampled with start
//    i_dir      in   1                0 = right (LSB out), 1 = left (MSB out)
//    i_chain    in   1                1 = all registers form one shift register
//    i_ser_in   in   NUM_REGS         per-register serial input, sampled live
//    o_ser_out  out  NUM_REGS         per-register serial output
//    o_busy     out  1                high while shifting
//    o_done     out  1                one-cycle pulse after the last shift
//    o_q        out  NUM_REGS*WIDTH   register i at o_q[i*WIDTH +: WIDTH]
// ============================================================================
module shift_reg_bank #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 3,
  parameter int CNT_W    = $clog2(NUM_REGS*WIDTH+1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [WIDTH-1:0]          i_d,
  input  logic [NUM_REGS-1:0]       i_ld,
  input  logic                      i_start,
  input  logic [CNT_W-1:0]          i_count,
  input  logic [NUM_REGS-1:0]       i_sel,
  input  logic                      i_dir,
  input  logic                      i_chain,
  input  logic [NUM_REGS-1:0]       i_ser_in,
  output logic [NUM_REGS-1:0]       o_ser_out,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [NUM_REGS*WIDTH-1:0] o_q
);

  localparam int TOT = NUM_REGS * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_REGS-1:0] r_sel_q;
  logic                r_dir_q;
  logic                r_chain_q;
  logic [TOT-1:0]      r_q;
  logic [TOT-1:0]      w_shift_q;
  logic [TOT-1:0]      w_load_q;
  logic                w_accept;

  // Start is only honoured in IDLE; elsewhere it is dropped, not queued.
  assign w_accept = (r_state == S_IDLE) && i_start;

  // --------------------------------------------------------------------------
  // FSM: next state and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          // A zero-length burst still produces its Done pulse.
          w_next_state = (i_count != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        o_busy = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        o_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: next value for one shift edge
  // --------------------------------------------------------------------------
  always_comb begin
    w_shift_q = r_q;
    if (r_chain_q) begin
      // Register NUM_REGS-1 is the most significant slice of the long word.
      if (r_dir_q) begin
        w_shift_q = {r_q[TOT-2:0], i_ser_in[0]};
      end else begin
        w_shift_q = {i_ser_in[NUM_REGS-1], r_q[TOT-1:1]};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_sel_q[i]) begin
          if (r_dir_q) begin
            w_shift_q[i*WIDTH +: WIDTH] = {r_q[i*WIDTH +: WIDTH-1], i_ser_in[i]};
          end else begin
            w_shift_q[i*WIDTH +: WIDTH] = {i_ser_in[i], r_q[i*WIDTH+1 +: WIDTH-1]};
          end
        end
      end
    end
  end

  // Datapath: parallel load (applies whenever not shifting)
  always_comb begin
    w_load_q = r_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_ld[i]) begin
        w_load_q[i*WIDTH +: WIDTH] = i_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register, burst parameters and register file
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sel_q   <= '0;
      r_dir_q   <= 1'b0;
      r_chain_q <= 1'b0;
      r_q       <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_cnt     <= i_count;
        r_sel_q   <= i_sel;
        r_dir_q   <= i_dir;
        r_chain_q <= i_chain;
      end else if (r_state == S_SHIFT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      // A load coinciding with Start lands first; the burst then shifts it.
      if (r_state == S_SHIFT) begin
        r_q <= w_shift_q;
      end else begin
        r_q <= w_load_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Serial outputs follow the latched direction, also while idle
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ser_out
      assign o_ser_out[g] = r_dir_q ? r_q[g*WIDTH + WIDTH - 1] : r_q[g*WIDTH];
    end
  endgenerate

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_reg_bank
//  Description : Self-checking bench for shift_reg_bank: directed vector
//                table, hand-written corner sequences and randomized bursts
//                checked against a word-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_reg_bank;

  localparam int W   = 8;
  localparam int N   = 3;
  localparam int TOT = N * W;
  localparam int CW  = $clog2(TOT + 1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   d;
  logic [N-1:0]   ld;
  logic           start;
  logic [CW-1:0]  count;
  logic [N-1:0]   sel;
  logic           dir;
  logic           chain;
  logic [N-1:0]   ser_in;
  logic [N-1:0]   ser_out;
  logic           busy;
  logic           done;
  logic [TOT-1:0] q;

  int n_pass  = 0;
  int n_total = 0;

  shift_reg_bank #(.WIDTH(W), .NUM_REGS(N)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_d       (d),
    .i_ld      (ld),
    .i_start   (start),
    .i_count   (count),
    .i_sel     (sel),
    .i_dir     (dir),
    .i_chain   (chain),
    .i_ser_in  (ser_in),
    .o_ser_out (ser_out),
    .o_busy    (busy),
    .o_done    (done),
    .o_q       (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    d = '0; ld = '0; start = 1'b0; count = '0; sel = '0;
    dir = 1'b0; chain = 1'b0; ser_in = '0;
  endtask

  task automatic load_all(input logic [TOT-1:0] init);
    for (int i = 0; i < N; i++) begin
      ld = N'(1) << i;
      d  = init[i*W +: W];
      step();
    end
    ld = '0;
  endtask

  // ---------------- reference model (word-level arithmetic) ----------------
  function automatic logic [TOT-1:0] model_shift(input logic [TOT-1:0] cur,
      input logic [N-1:0] s, input logic dr, input logic ch, input logic [N-1:0] si);
    logic [TOT-1:0] r;
    logic [W-1:0]   b;
    r = cur;
    if (ch) begin
      if (dr) r = cur * 2 + si[0];
      else    r = cur / 2 + (si[N-1] ? (TOT'(1) << (TOT-1)) : TOT'(0));
    end else begin
      for (int i = 0; i < N; i++) begin
        b = cur[i*W +: W];
        if (s[i]) begin
          if (dr) b = b * 2 + si[i];
          else    b = b / 2 + (si[i] ? W'(1 << (W-1)) : W'(0));
        end
        r[i*W +: W] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] model_ser(input logic [TOT-1:0] cur, input logic dr);
    logic [N-1:0] o;
    logic [W-1:0] b;
    for (int i = 0; i < N; i++) begin
      b    = cur[i*W +: W];
      o[i] = dr ? b[W-1] : b[0];
    end
    return o;
  endfunction

  function automatic logic [TOT-1:0] model_load(input logic [TOT-1:0] cur,
      input logic [N-1:0] l, input logic [W-1:0] dv);
    logic [TOT-1:0] r;
    r = cur;
    for (int i = 0; i < N; i++) if (l[i]) r[i*W +: W] = dv;
    return r;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [TOT-1:0] init;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   sel;
    logic           dir;
    logic           chain;
    logic [N-1:0]   si;
    logic [TOT-1:0] exp;
  } vec_t;

  vec_t tv[7];

  task automatic run_vec(input int idx, input vec_t v);
    int nb;
    int nd;
    load_all(v.init);
    start = 1'b1; count = v.cnt; sel = v.sel; dir = v.dir; chain = v.chain; ser_in = v.si;
    step();
    start = 1'b0;
    nb = 0; nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        break;
      end
      step();
    end
    check($sformatf("vec%0d_q", idx), q, v.exp);
    check($sformatf("vec%0d_busy_cycles", idx), nb, v.cnt);
    check($sformatf("vec%0d_done_seen", idx), nd, 1);
    step();
    check($sformatf("vec%0d_done_single", idx), done, 1'b0);
    ser_in = '0;
  endtask

  // ---------------- randomized burst against the model ----------------
  task automatic run_random(input int idx);
    logic [TOT-1:0] mq;
    logic [N-1:0]   m_sel;
    logic           m_dir;
    logic           m_chain;
    int             n;
    mq = q;
    n  = $urandom_range(0, 12);
    m_sel = N'($urandom); m_dir = 1'($urandom); m_chain = 1'($urandom);
    start = 1'b1; count = CW'(n); sel = m_sel; dir = m_dir; chain = m_chain;
    ld = N'($urandom); d = W'($urandom); ser_in = N'($urandom);
    mq = model_load(mq, ld, d);
    step();
    for (int j = 0; j < n; j++) begin
      check($sformatf("rnd%0d_busy", idx), busy, 1'b1);
      check($sformatf("rnd%0d_q", idx), q, mq);
      check($sformatf("rnd%0d_ser_out", idx), ser_out, model_ser(mq, m_dir));
      // Start and Ld during the burst must have no effect.
      start = 1'($urandom); ld = N'($urandom); d = W'($urandom); ser_in = N'($urandom);
      mq = model_shift(mq, m_sel, m_dir, m_chain, ser_in);
      step();
    end
    check($sformatf("rnd%0d_done", idx), {busy, done}, 2'b01);
    check($sformatf("rnd%0d_q_end", idx), q, mq);
    // Loads are accepted in the Done cycle; Start is not.
    start = 1'($urandom); ld = N'($urandom); d = W'($urandom);
    mq = model_load(mq, ld, d);
    step();
    start = 1'b0; ld = '0;
    check($sformatf("rnd%0d_idle", idx), {busy, done}, 2'b00);
    check($sformatf("rnd%0d_q_idle", idx), q, mq);
    check($sformatf("rnd%0d_ser_idle", idx), ser_out, model_ser(mq, m_dir));
  endtask

  logic [8:0]     ser_seq;
  logic [TOT-1:0] saved;

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    //               init        cnt   sel     dir   chain si      exp
    tv[0] = '{24'h5AC3B4,  CW'(4),  3'b001, 1'b0, 1'b0, 3'b000, 24'h5AC30B};
    tv[1] = '{24'h000081,  CW'(9),  3'b000, 1'b0, 1'b1, 3'b000, 24'h000000};
    tv[2] = '{24'h008000,  CW'(1),  3'b000, 1'b1, 1'b1, 3'b001, 24'h010001};
    tv[3] = '{24'h123456,  CW'(0),  3'b111, 1'b1, 1'b0, 3'b111, 24'h123456};
    tv[4] = '{24'hF00FAA,  CW'(3),  3'b110, 1'b1, 1'b0, 3'b111, 24'h877FAA};
    tv[5] = '{24'hFFFFFF,  CW'(10), 3'b111, 1'b0, 1'b0, 3'b000, 24'h000000};
    tv[6] = '{24'h000000,  CW'(4),  3'b010, 1'b0, 1'b1, 3'b100, 24'hF00000};

    #12;
    check("reset_q", q, 0);
    check("reset_status", {busy, done, ser_out}, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_vec(i, tv[i]);

    // Chain right: Ser_Out[0] carries the long word out LSB first.
    load_all(24'h000081);
    start = 1'b1; count = CW'(9); sel = '0; dir = 1'b0; chain = 1'b1;
    step();
    start = 1'b0;
    ser_seq = 9'b010000001;
    for (int j = 0; j < 9; j++) begin
      check($sformatf("chain_ser_out%0d", j), ser_out[0], ser_seq[j]);
      step();
    end
    check("chain_done_q", {done, q}, {1'b1, 24'h000000});
    step();

    // Start and Ld during a burst are ignored and Start is not queued.
    load_all(24'h112233);
    start = 1'b1; count = CW'(3); sel = 3'b001; dir = 1'b0; chain = 1'b0;
    step();
    ld = 3'b111; d = 8'hFF;
    for (int j = 0; j < 3; j++) step();
    start = 1'b0; ld = '0;
    check("ignore_q", q, 24'h112206);
    check("ignore_done", done, 1'b1);
    step();
    check("ignore_no_requeue0", {busy, done}, 2'b00);
    step();
    check("ignore_no_requeue1", {busy, done}, 2'b00);

    // Start with Ld on the same edge: the loaded value is shifted.
    start = 1'b1; ld = 3'b001; d = 8'hFF; count = CW'(8); sel = 3'b001; dir = 1'b1;
    step();
    start = 1'b0; ld = '0;
    for (int j = 0; j < 8; j++) step();
    check("startld_done", done, 1'b1);
    check("startld_q", q, 24'h112200);
    step();

    // Asynchronous reset after 3 of 8 shifts.
    load_all(24'hA5A5A5);
    start = 1'b1; count = CW'(8); sel = 3'b111; dir = 1'b1; chain = 1'b0; ser_in = 3'b111;
    step();
    start = 1'b0;
    for (int j = 0; j < 3; j++) step();
    saved = q;
    check("pre_reset_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_q", q, 0);
    check("async_reset_status", {busy, done, ser_out}, 0);
    step();
    rst_n = 1'b1;
    ser_in = '0;
    step();
    check("post_reset_idle", {busy, done, q}, 0);

    for (int i = 0; i < 25; i++) run_random(i);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard bound on simulation length.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire
